wb_trace_fifo: RTL and testbench
================================

Name: wb_trace_fifo

Overview:
- Trace buffer that sits directly downstream of the processor top level.
- Captures every architectural register write and queues it for an external debug/display consumer.
- Each write is captured as the triple (pc, ctrlWriteReg, dataWriteReg).
- Exposes a valid/ready drain port, occupancy, and overflow accounting.
- Runs on the processor clock so that exactly one write event is sampled per processor cycle.

Parameters:
- DEPTH, 16: number of entries; must be a power of two, 2..256.
- AW, 4: pointer width; must equal log2(DEPTH).
- DROP_W, 16: width of the saturating dropped-event counter.

Ports:
- clock  in  1  processor clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- wb_en  in  1  regfile write enable for this cycle.
- wb_reg  in  5  destination register (ctrlWriteReg).
- wb_data  in  32  write data (dataWriteReg).
- wb_pc  in  12  pc of the writing instruction.
- freeze  in  1  when 1, no new events are captured; drain continues.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry.
- out_pc  out  12  pc field of the head entry.
- out_reg  out  5  register field of the head entry.
- out_data  out  32  data field of the head entry.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: at least one event was dropped.
- drop_cnt  out  DROP_W  number of dropped events, saturating.

Behaviour:
- Reset (sync, high):
  - Read/write pointers and count go to 0.
  - out_valid = 0, overflow = 0, drop_cnt = 0.
  - out_pc, out_reg and out_data go to 0.
  - Storage contents are don't-care.
  - Reset asserted mid-stream discards all entries; a concurrent push or pop in that cycle is ignored.
- Capture condition: cap = wb_en & (wb_reg != 0) & ~freeze. Writes to r0 are never recorded.
- Pop: pop = out_valid & out_ready.
- Push: push = cap & (~full | pop).
  - When full and popping in the same cycle, the new entry is accepted and count is unchanged.
- Drop: drop = cap & full & ~pop.
  - overflow is set to 1 and stays set until reset.
  - drop_cnt increments and saturates at 2^DROP_W-1.
- Count update: count <= count + push - pop. full = (count == DEPTH); empty = (count == 0).
- Output ordering: FIFO order, first-word-fall-through.
  - out_* always show the head entry whenever out_valid = 1.
  - out_* hold their values while out_valid & ~out_ready.
- Latency: an entry captured on edge N has out_valid = 1 after edge N when the FIFO was empty beforehand (one cycle, no bypass of the register stage).
- Pointer wrap: pointers are AW bits wide and wrap modulo DEPTH; no extra state is required.
- Empty FIFO: out_valid = 0 and out_ready is ignored. out_* keep their last value, and consumers must not rely on them.
- Push and pop in the same cycle on a FIFO holding 1 entry:
  - The head advances to the new entry.
  - out_valid stays 1.
- freeze:
  - Has no effect on draining.
  - Events gated by freeze are not counted as drops.
- No combinational path from wb_* to out_*.
- No combinational path from out_ready to out_valid.

Test Plan:
- Reset then idle → out_valid=0, count=0, overflow=0, drop_cnt=0.
- Single write {wb_en=1, wb_reg=3, wb_data=0x0000002A, wb_pc=0x005} with out_ready=0 → one cycle later out_valid=1, out_reg=3, out_data=0x2A, out_pc=0x005, count=1. Pulse out_ready → count=0, out_valid=0.
- Writes to r0, and writes with freeze=1 → count stays 0 and drop_cnt stays 0.
- Fill to 16 entries with wb_data=1..16 and out_ready=0, then 3 more writes → count=16, overflow=1, drop_cnt=3. Draining then yields data 1..16 in order.
- Full FIFO with continuous writes and out_ready=1 held → count stays 16 and drop_cnt does not change. Output sequence is contiguous with no gaps across pointer wrap (≥40 entries).
- Reset asserted while holding 5 entries with push and pop active → next cycle count=0, out_valid=0, overflow=0. A subsequent write is delivered as the first entry.

Source files
------------

// File: rtl/wb_trace_fifo.sv
// Register-write trace FIFO: records (pc, reg, data) for every nonzero-register
// write and presents them first-word-fall-through with overflow accounting.
module wb_trace_fifo #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int DROP_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_en,
    input  logic [4:0]        wb_reg,
    input  logic [31:0]       wb_data,
    input  logic [11:0]       wb_pc,
    input  logic              freeze,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [11:0]       out_pc,
    output logic [4:0]        out_reg,
    output logic [31:0]       out_data,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);
    localparam int EW = 49;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [AW:0]   cnt_nxt, cnt_after_pop;
    logic [EW-1:0] wb_entry, head_nxt;
    logic          cap, full, pop, push, drop;

    assign wb_entry = {wb_pc, wb_reg, wb_data};

    always_comb begin
        full          = (count == (AW+1)'(DEPTH));
        cap           = wb_en & (wb_reg != 5'd0) & ~freeze;
        pop           = out_valid & out_ready;
        push          = cap & (~full | pop);
        drop          = cap & full & ~pop;
        rd_nxt        = rd_ptr + AW'(pop);
        cnt_after_pop = count - (AW+1)'(pop);
        cnt_nxt       = cnt_after_pop + (AW+1)'(push);
        // Output registers track the head after this edge; if the FIFO drains
        // to the incoming entry, it comes straight from the write port.
        head_nxt = {out_pc, out_reg, out_data};
        if (cnt_nxt != '0) begin
            if (cnt_after_pop == '0)
                head_nxt = wb_entry;
            else
                head_nxt = mem[rd_nxt];
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= wb_entry;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_reg   <= '0;
            out_data  <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(push);
            rd_ptr    <= rd_nxt;
            count     <= cnt_nxt;
            out_valid <= (cnt_nxt != '0);
            {out_pc, out_reg, out_data} <= head_nxt;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1)
                    drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_wb_trace_fifo.sv
// Bench for wb_trace_fifo: directed steps plus random traffic against a
// queue-based reference of the trace buffer.
module tb_wb_trace_fifo;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int DROP_W = 16;

    logic              clock = 1'b0;
    logic              reset, wb_en, freeze, out_ready, out_valid, overflow;
    logic [4:0]        wb_reg, out_reg;
    logic [31:0]       wb_data, out_data;
    logic [11:0]       wb_pc, out_pc;
    logic [AW:0]       count;
    logic [DROP_W-1:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [48:0] q[$];
    logic [48:0] m_last;
    bit          m_ovf;
    int          m_drop;

    wb_trace_fifo #(.DEPTH(DEPTH), .AW(AW), .DROP_W(DROP_W)) dut (
        .clock(clock), .reset(reset), .wb_en(wb_en), .wb_reg(wb_reg),
        .wb_data(wb_data), .wb_pc(wb_pc), .freeze(freeze),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_reg(out_reg), .out_data(out_data), .count(count),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid", 64'(out_valid), 64'(q.size() != 0));
        chk("count", 64'(count), 64'(q.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        chk("head", 64'({out_pc, out_reg, out_data}), 64'(m_last));
    endtask

    // Drive one cycle's inputs, advance the reference at the edge, check after.
    task automatic step(bit en, logic [4:0] r, logic [31:0] d, logic [11:0] pc,
                        bit frz, bit rdy, bit rst);
        bit p, c, f;
        wb_en = en; wb_reg = r; wb_data = d; wb_pc = pc;
        freeze = frz; out_ready = rdy; reset = rst;
        @(posedge clock);
        if (rst) begin
            q.delete();
            m_ovf  = 0;
            m_drop = 0;
            m_last = '0;
        end else begin
            p = (q.size() > 0) && rdy;
            c = en && (r != 5'd0) && !frz;
            f = (q.size() == DEPTH);
            if (p) void'(q.pop_front());
            if (c && (!f || p))
                q.push_back({pc, r, d});
            else if (c) begin
                m_ovf = 1;
                if (m_drop < (1 << DROP_W) - 1) m_drop++;
            end
            if (q.size() > 0) m_last = q[0];
        end
        @(negedge clock);
        check_all();
    endtask

    initial begin
        int exp_seq;
        reset = 1'b1; wb_en = 0; wb_reg = 0; wb_data = 0; wb_pc = 0;
        freeze = 0; out_ready = 0;
        m_last = '0; m_ovf = 0; m_drop = 0;
        @(negedge clock);

        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);

        // Single write, one-cycle visibility, then drain.
        step(1, 5'd3, 32'h2A, 12'h005, 0, 0, 0);
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_reg", 64'(out_reg), 64'd3);
        chk("single_data", 64'(out_data), 64'h2A);
        chk("single_pc", 64'(out_pc), 64'h005);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("single_drained", 64'(count), 64'd0);

        // r0 writes and frozen writes are neither captured nor dropped.
        for (int i = 0; i < 3; i++) step(1, 5'd0, 32'(i), 12'(i), 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 5'd7, 32'(i), 12'(i), 1, 0, 0);
        chk("gated_count", 64'(count), 64'd0);
        chk("gated_drop", 64'(drop_cnt), 64'd0);

        // Fill, overflow by three, drain in order.
        for (int i = 1; i <= 16; i++) step(1, 5'(i), 32'(i), 12'(i), 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 5'd9, 32'hDEAD, 12'h0, 0, 0, 0);
        chk("full_count", 64'(count), 64'd16);
        chk("full_ovf", 64'(overflow), 64'd1);
        chk("full_drop", 64'(drop_cnt), 64'd3);
        for (int i = 1; i <= 16; i++) begin
            chk("drain_order", 64'(out_data), 64'(i));
            step(0, 0, 0, 0, 0, 1, 0);
        end

        // Full with simultaneous push/pop across pointer wrap.
        for (int k = 0; k < 16; k++) step(1, 5'd6, 32'(100 + k), 12'(k), 0, 0, 0);
        exp_seq = 100;
        for (int j = 0; j < 45; j++) begin
            chk("stream_seq", 64'(out_data), 64'(exp_seq));
            step(1, 5'd7, 32'(116 + j), 12'(j), 0, 1, 0);
            exp_seq++;
        end
        chk("stream_count", 64'(count), 64'd16);
        chk("stream_drop", 64'(drop_cnt), 64'd3);

        // Reset mid-stream with push and pop active.
        for (int i = 0; i < 11; i++) step(0, 0, 0, 0, 0, 1, 0);
        chk("pre_rst_count", 64'(count), 64'd5);
        step(1, 5'd9, 32'h1234, 12'h55, 0, 1, 1);
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_ovf", 64'(overflow), 64'd0);
        step(1, 5'd4, 32'hBEEF, 12'h123, 0, 0, 0);
        chk("post_rst_data", 64'(out_data), 64'hBEEF);

        // Random traffic with phases of low and high drain pressure.
        for (int j = 0; j < 600; j++) begin
            step(($urandom % 4) != 0, 5'($urandom % 32), $urandom, 12'($urandom),
                 ($urandom % 16) == 0,
                 ($urandom % 8) < ((j % 200) < 100 ? 2 : 6),
                 ($urandom % 250) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
